// File: rtl/instr_decode.sv
// instr_decode: RV32I decode stage with a 32x32 register file and a one-entry registered output bundle.
// Optional macro DECODE_WB_BYPASS_EN forwards same-cycle writeback data into the captured source operands.
module instr_decode #(
    parameter bit REGFILE_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instruction,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] imm,
    output logic [4:0]  rd,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic        illegal
);

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t      r_state;
    logic [31:0] r_regs [32];
    logic [31:0] r_rs1_data;
    logic [31:0] r_rs2_data;
    logic [31:0] r_imm;
    logic [4:0]  r_rd;
    logic [6:0]  r_opcode;
    logic [2:0]  r_funct3;
    logic        r_funct7b5;
    logic        r_illegal;

    logic        w_accept;
    logic        w_wb_write;
    logic [4:0]  w_rs1_idx;
    logic [4:0]  w_rs2_idx;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_imm;
    logic        w_illegal;

    assign w_rs1_idx  = instruction[19:15];
    assign w_rs2_idx  = instruction[24:20];
    assign w_wb_write = wb_en && (wb_rd != 5'd0);

    assign out_valid = (r_state == S_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;

    // NOTE: the array is only cleared when REGFILE_RESET is set; otherwise it carries no reset and can map to RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (REGFILE_RESET) begin
                for (int i = 0; i < 32; i++) begin
                    r_regs[i] <= '0;
                end
            end
        end else if (w_wb_write) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // Operand read; x0 is forced to zero independent of array contents.
    always_comb begin
        w_rs1_val = (w_rs1_idx == 5'd0) ? 32'd0 : r_regs[w_rs1_idx];
        w_rs2_val = (w_rs2_idx == 5'd0) ? 32'd0 : r_regs[w_rs2_idx];
`ifdef DECODE_WB_BYPASS_EN
        if (w_wb_write && (wb_rd == w_rs1_idx)) w_rs1_val = wb_data;
        if (w_wb_write && (wb_rd == w_rs2_idx)) w_rs2_val = wb_data;
`endif
    end

    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        w_imm     = '0;
        w_illegal = 1'b0;
        case (instruction[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
                w_imm = {{20{instruction[31]}}, instruction[31:20]};
            7'b0100011:
                w_imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            7'b1100011:
                w_imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                         instruction[30:25], instruction[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                w_imm = {instruction[31:12], 12'b0};
            7'b1101111:
                w_imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                         instruction[20], instruction[30:21], 1'b0};
            7'b0110011:
                w_imm = '0;
            default:
                w_illegal = 1'b1;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rd       <= '0;
            r_opcode   <= '0;
            r_funct3   <= '0;
            r_funct7b5 <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: if (w_accept) r_state <= S_FULL;
                S_FULL:  if (!w_accept && out_ready) r_state <= S_EMPTY;
                default: r_state <= S_EMPTY;
            endcase
            // A held bundle only changes on an accept, which already implies out_ready while FULL.
            if (w_accept) begin
                r_rs1_data <= w_rs1_val;
                r_rs2_data <= w_rs2_val;
                r_imm      <= w_imm;
                r_rd       <= w_illegal ? 5'd0 : instruction[11:7];
                r_opcode   <= instruction[6:0];
                r_funct3   <= instruction[14:12];
                r_funct7b5 <= instruction[30];
                r_illegal  <= w_illegal;
            end
        end
    end

    assign rs1_data = r_rs1_data;
    assign rs2_data = r_rs2_data;
    assign imm      = r_imm;
    assign rd       = r_rd;
    assign opcode   = r_opcode;
    assign funct3   = r_funct3;
    assign funct7b5 = r_funct7b5;
    assign illegal  = r_illegal;

endmodule

// File: tb/tb_instr_decode.sv
// Scoreboard bench for instr_decode: a driver pushes expected bundles at acceptance, a negedge monitor checks them.
// Honours DECODE_WB_BYPASS_EN the same way as the design build.
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instruction = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        illegal;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        ill;
    } bundle_t;

    bundle_t     sb_q[$];
    logic [31:0] m_regs [32];
    logic        m_valid = 1'b0;
    logic        m_zero  = 1'b1;
    logic        mon_en  = 1'b0;
    int          n_vec   = 0;
    int          n_err   = 0;

    logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                             7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h12};

    instr_decode dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .imm(imm), .rd(rd), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Register value as seen by an instruction accepted in a cycle with the given writeback inputs.
    function automatic logic [31:0] src_val(input logic [4:0] idx, input logic we,
                                            input logic [4:0] wrd, input logic [31:0] wd);
        if (idx == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (we && wrd == idx) return wd;
`endif
        return m_regs[idx];
    endfunction

    // Immediates rebuilt from field weights with signed integer arithmetic.
    function automatic bundle_t model(input logic [31:0] ins, input logic we,
                                      input logic [4:0] wrd, input logic [31:0] wd);
        bundle_t b;
        int      v;
        int      sgn;
        b.rs1 = src_val(ins[19:15], we, wrd, wd);
        b.rs2 = src_val(ins[24:20], we, wrd, wd);
        b.op  = ins[6:0];
        b.f3  = ins[14:12];
        b.f7  = ins[30];
        b.rd  = ins[11:7];
        b.ill = 1'b0;
        sgn   = ins[31] ? 1 : 0;
        v     = 0;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: v = int'(ins[31:20]) - sgn * 4096;
            7'h23: v = int'(ins[31:25]) * 32 + int'(ins[11:7]) - sgn * 4096;
            7'h63: v = int'(ins[11:8]) * 2 + int'(ins[30:25]) * 32 + int'(ins[7]) * 2048 - sgn * 4096;
            7'h37, 7'h17: v = int'(ins[31:12] * 20'd1) * 4096;
            7'h6F: v = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096
                       - sgn * (1 << 20);
            7'h33: v = 0;
            default: begin
                b.ill = 1'b1;
                b.rd  = '0;
            end
        endcase
        b.imm = 32'(v);
        return b;
    endfunction

    task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic we,
                        input logic [4:0] wrd, input logic [31:0] wd, input logic r);
        bit acc;
        in_valid    = v;
        instruction = ins;
        out_ready   = ordy;
        wb_en       = we;
        wb_rd       = wrd;
        wb_data     = wd;
        rst         = r;
        acc = !r && v && (!m_valid || ordy);
        if (acc) sb_q.push_back(model(ins, we, wrd, wd));
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0;
            m_zero  = 1'b1;
            sb_q.delete();
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
        end else begin
            if (acc) begin
                m_valid = 1'b1;
                m_zero  = 1'b0;
            end else if (ordy) begin
                m_valid = 1'b0;
            end
            if (we && wrd != 5'd0) m_regs[wrd] = wd;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_empty: out_valid=1 with no expected bundle at %0t", $time);
                end else begin
                    check("rs1_data", rs1_data, sb_q[0].rs1);
                    check("rs2_data", rs2_data, sb_q[0].rs2);
                    check("imm", imm, sb_q[0].imm);
                    check("rd", 32'(rd), 32'(sb_q[0].rd));
                    check("opcode", 32'(opcode), 32'(sb_q[0].op));
                    check("funct3", 32'(funct3), 32'(sb_q[0].f3));
                    check("funct7b5", 32'(funct7b5), 32'(sb_q[0].f7));
                    check("illegal", 32'(illegal), 32'(sb_q[0].ill));
                    if (out_ready) void'(sb_q.pop_front());
                end
            end else if (m_zero) begin
                check("rst_rs1", rs1_data, 32'd0);
                check("rst_rs2", rs2_data, 32'd0);
                check("rst_imm", imm, 32'd0);
                check("rst_fields", {14'd0, rd, opcode, funct3, funct7b5, illegal}, 32'd0);
            end
        end
    end

    initial begin
        logic [31:0] rnd;
        logic [31:0] ins;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1);
        mon_en = 1'b1;

        // x5 = 0xAA, then addi x5,x5,5
        step(1'b0, 32'h0, 1'b1, 1'b1, 5'd5, 32'h0000_00AA, 1'b0);
        step(1'b1, 32'h0052_8293, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        // beq with negative offset, then an all-zero word, back to back
        step(1'b1, 32'hFE00_0EE3, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0000, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        // three stall cycles with in_valid held, then replacement without a bubble
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0010_0093, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b1, 32'h0010_0093, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b1, 32'h0020_0113, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        // accept addi x1,x7,0 in the same cycle as a write to x7
        step(1'b1, 32'h0003_8093, 1'b1, 1'b1, 5'd7, 32'h0000_1234, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        // reset while FULL and stalled, then read x5
        step(1'b1, 32'h0002_8293, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b1, 32'h0002_8293, 1'b0, 1'b1, 5'd3, 32'h5555_5555, 1'b1);
        step(1'b1, 32'h0002_8293, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        // write attempt to x0, then read x0
        step(1'b0, 32'h0, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        step(1'b1, 32'h0000_0013, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);

        for (int n = 0; n < 600; n++) begin
            rnd = $urandom;
            ins = {rnd[31:7], ops[$urandom_range(0, 11)]};
            if ($urandom_range(0, 7) == 0) ins = $urandom;
            step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 60) == 0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
